// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract: streams WORDS 32-bit slices through one prefix adder, LS word first.
// Latency WORDS+1 edges from accepted start to the done pulse; one operation per WORDS+2 cycles.
// No backpressure: start is honoured only in IDLE; requests while busy or in DONE are dropped.

// 32-bit Kogge-Stone prefix adder with carry-in; purely combinational.
module prefix_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out
);

  logic [31:0] g, p, gn, pn, c;

  // Five prefix levels combine (generate, propagate) pairs over spans 1,2,4,8,16.
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gn = g;
    pn = p;
    for (int k = 0; k < 5; k++) begin
      gn = g;
      pn = p;
      for (int i = (1 << k); i < 32; i++) begin
        gn[i] = g[i] | (p[i] & g[i - (1 << k)]);
        pn[i] = p[i] & p[i - (1 << k)];
      end
      g = gn;
      p = pn;
    end
    // Carry into bit i is the group (g,p) of bits i-1..0 applied to c_in.
    c[0] = c_in;
    for (int i = 1; i < 32; i++) begin
      c[i] = g[i-1] | (p[i-1] & c_in);
    end
    s     = a ^ b ^ c;
    c_out = g[31] | (p[31] & c_in);
  end

endmodule

module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                sub,
  input  logic                cin,
  input  logic [32*WORDS-1:0] a_in,
  input  logic [32*WORDS-1:0] b_in,
  output logic                busy,
  output logic                done,
  output logic [32*WORDS-1:0] result,
  output logic                carry_out,
  output logic                overflow
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q;
  logic [IW-1:0]          idx_q;
  logic [WORDS-1:0][31:0] opa_q;
  logic [WORDS-1:0][31:0] opb_q;
  logic [WORDS-1:0][31:0] result_q;
  logic                   carry_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   carry_out_q;
  logic                   overflow_q;

  logic [31:0] word_a, word_b, word_s;
  logic        word_c;
  logic        last_word;
  logic        word_ovf;

  // Current slice of each latched operand; opB already holds ~b for subtraction.
  assign word_a    = opa_q[idx_q];
  assign word_b    = opb_q[idx_q];
  assign last_word = (idx_q == IW'(WORDS - 1));
  // Signed overflow of the full operation, judged on the MS word's sign bits.
  assign word_ovf  = (word_a[31] == word_b[31]) && (word_s[31] != word_a[31]);

  prefix_adder_32bit u_add (
    .a     (word_a),
    .b     (word_b),
    .c_in  (carry_q),
    .s     (word_s),
    .c_out (word_c)
  );

  // Sequencer FSM: latch operands on start, ripple one word per edge, pulse done once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= RUN;
            busy_q      <= 1'b1;
            opa_q       <= a_in;
            opb_q       <= sub ? ~b_in : b_in;
            // Subtraction is a + ~b + 1, so the incoming carry is forced to 1.
            carry_q     <= sub | cin;
            idx_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
          end
        end
        RUN: begin
          result_q[idx_q] <= word_s;
          carry_q         <= word_c;
          if (last_word) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            idx_q       <= '0;
            carry_out_q <= word_c;
            overflow_q  <= word_ovf;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: WORDS=4 instance against a cycle-level reference model,
// plus a WORDS=1 instance for the single-word latency case.
module tb_wide_add_sequencer;

  localparam int N4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst4, rst1;
  logic         start4 = 1'b0, sub4 = 1'b0, cin4 = 1'b0;
  logic [127:0] a4 = '0, b4 = '0;
  logic         busy4, done4, co4, ov4;
  logic [127:0] res4;

  logic         start1 = 1'b0, sub1 = 1'b0, cin1 = 1'b0;
  logic [31:0]  a1 = '0, b1 = '0;
  logic         busy1, done1, co1, ov1;
  logic [31:0]  res1;

  wide_add_sequencer #(.WORDS(N4)) dut4 (
    .clk(clk), .reset(rst4), .start(start4), .sub(sub4), .cin(cin4),
    .a_in(a4), .b_in(b4), .busy(busy4), .done(done4), .result(res4),
    .carry_out(co4), .overflow(ov4)
  );

  wide_add_sequencer #(.WORDS(1)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .sub(sub1), .cin(cin1),
    .a_in(a1), .b_in(b1), .busy(busy1), .done(done1), .result(res1),
    .carry_out(co1), .overflow(ov1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic on whole 128-bit integers: returns {overflow, carry_out, result}.
  function automatic logic [129:0] ref_op(input logic [127:0] a, input logic [127:0] b,
                                          input logic s, input logic ci);
    logic [128:0] u;
    logic [129:0] sx, rx;
    logic [127:0] r;
    logic         co;
    if (s) begin
      u  = {1'b0, a} - {1'b0, b};
      co = ~u[128];                       // no borrow <=> a >= b unsigned
      sx = {{2{a[127]}}, a} - {{2{b[127]}}, b};
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {128'b0, ci};
      co = u[128];
      sx = {{2{a[127]}}, a} + {{2{b[127]}}, b} + {129'b0, ci};
    end
    r  = u[127:0];
    rx = {{2{r[127]}}, r};
    return {(sx != rx), co, r};
  endfunction

  function automatic logic [127:0] rnd_operand();
    logic [127:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 3))
        0:       v[i*32 +: 32] = 32'h0;
        1:       v[i*32 +: 32] = 32'hFFFF_FFFF;
        default: v[i*32 +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  // Cycle-level model of the WORDS=4 instance, driven by edge count since the accepted start.
  int           ecnt = 0;
  bit           m_act = 1'b0;
  int           m_t0 = 0;
  bit           m_known = 1'b1;
  logic [127:0] m_res = '0, p_res = '0;
  logic         m_co = 1'b0, m_ov = 1'b0, p_co = 1'b0, p_ov = 1'b0;

  always @(posedge clk or posedge rst4) begin
    if (rst4) begin
      m_act = 1'b0; m_known = 1'b1; m_res = '0; m_co = 1'b0; m_ov = 1'b0;
    end else begin
      ecnt++;
      if (start4 && (!m_act || ecnt >= m_t0 + N4 + 2)) begin
        {p_ov, p_co, p_res} = ref_op(a4, b4, sub4, cin4);
        m_t0 = ecnt; m_act = 1'b1; m_known = 1'b0; m_co = 1'b0; m_ov = 1'b0;
      end else if (m_act && ecnt == m_t0 + N4) begin
        m_res = p_res; m_co = p_co; m_ov = p_ov; m_known = 1'b1;
      end
    end
  end

  // Compare every cycle, half a period after the active edge.
  logic e_busy, e_done;
  always @(negedge clk) begin
    e_busy = m_act && (ecnt >= m_t0) && (ecnt <= m_t0 + N4);
    e_done = m_act && (ecnt == m_t0 + N4);
    chk("busy", busy4, e_busy);
    chk("done", done4, e_done);
    chk("carry_out", co4, m_co);
    chk("overflow", ov4, m_ov);
    if (m_known) chk("result", res4, m_res);
  end

  task automatic drive(input int which, input logic st, input logic [127:0] a,
                       input logic [127:0] b, input logic s, input logic ci);
    if (which == 4) begin
      start4 = st; a4 = a; b4 = b; sub4 = s; cin4 = ci;
    end else begin
      start1 = st; a1 = a[31:0]; b1 = b[31:0]; sub1 = s; cin1 = ci;
    end
  endtask

  // One operation: start, scramble inputs after E0 (optionally re-pulse start), wait for done.
  task automatic run_op(input int which, input logic [127:0] a, input logic [127:0] b,
                        input logic s, input logic ci, input int noise_at, input bit dstart,
                        output logic [127:0] r, output logic co, output logic ov,
                        output int lat, output int bc);
    bit dn;
    lat = 0; bc = 0; r = '0; co = 1'b0; ov = 1'b0; dn = 1'b0;
    @(posedge clk); #2;
    drive(which, 1'b1, a, b, s, ci);
    while (lat < 20 && !dn) begin
      @(posedge clk); lat++; #2;
      drive(which, (lat == noise_at), rnd_operand(), rnd_operand(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(negedge clk);
      if ((which == 4) ? busy4 : busy1) bc++;
      dn = (which == 4) ? done4 : done1;
    end
    if (which == 4) begin
      r = res4; co = co4; ov = ov4;
    end else begin
      r = {96'b0, res1}; co = co1; ov = ov1;
    end
    if (dstart) begin
      drive(which, 1'b1, rnd_operand(), rnd_operand(), 1'b0, 1'b0);
      @(posedge clk); #2;
      drive(which, 1'b0, '0, '0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    logic [127:0] ones, r, ra, rb;
    logic         co, ov, rs, rc;
    logic [129:0] e;
    int           lat, bc, nd, nb;

    ones = '1;
    rst4 = 1'b1;
    rst1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_result", res4, 128'h0);
    chk("rst_flags", {co4, ov4}, 2'b00);
    @(posedge clk); #2;
    rst4 = 1'b0;
    rst1 = 1'b0;

    // Pin the reference model with hand-computed values.
    chk("model_c1", ref_op(128'd1, ones, 1'b0, 1'b0), {2'b01, 128'h0});
    chk("model_c3", ref_op(128'd10, 128'd20, 1'b1, 1'b0), {2'b00, ~128'd9});
    chk("model_c4", ref_op({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0), {2'b10, 1'b1, 127'b0});

    // Case 1: 1 + all-ones wraps to zero with carry; latency WORDS+1 edges.
    run_op(4, 128'd1, ones, 1'b0, 1'b0, 0, 1'b0, r, co, ov, lat, bc);
    chk("c1_res", r, 128'h0);
    chk("c1_co", co, 1'b1);
    chk("c1_ov", ov, 1'b0);
    chk("c1_lat", lat, N4 + 1);

    // Case 2: carry-in ripples through every word.
    run_op(4, ones, 128'd0, 1'b0, 1'b1, 0, 1'b0, r, co, ov, lat, bc);
    chk("c2_res", r, 128'h0);
    chk("c2_flags", {co, ov}, 2'b10);

    // Case 3: 10 - 20 borrows.
    run_op(4, 128'd10, 128'd20, 1'b1, 1'b1, 0, 1'b0, r, co, ov, lat, bc);
    chk("c3_res", r, {{31{4'hF}}, 4'h6});
    chk("c3_flags", {co, ov}, 2'b00);

    // Case 4: signed overflow on add and on subtract.
    run_op(4, {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, 0, 1'b0, r, co, ov, lat, bc);
    chk("c4a_res", r, {1'b1, 127'b0});
    chk("c4a_flags", {co, ov}, 2'b01);
    run_op(4, {1'b1, 127'b0}, 128'd1, 1'b1, 1'b0, 0, 1'b0, r, co, ov, lat, bc);
    chk("c4b_res", r, {1'b0, {127{1'b1}}});
    chk("c4b_ov", ov, 1'b1);

    // Case 5: second start during RUN and start held in DONE are both dropped.
    run_op(4, 128'd5, 128'd7, 1'b0, 1'b0, 2, 1'b1, r, co, ov, lat, bc);
    chk("c5_res", r, 128'd12);
    chk("c5_busy_cycles", bc, N4 + 1);
    nd = 0; nb = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) nd++;
      if (busy4) nb++;
    end
    chk("c5_extra_done", nd, 0);
    chk("c5_extra_busy", nb, 0);

    // Case 6: reset on the second RUN cycle aborts without a done pulse.
    @(posedge clk); #2;
    drive(4, 1'b1, ones, ones, 1'b0, 1'b0);
    @(posedge clk); #2;
    drive(4, 1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("c6_busy_before", busy4, 1'b1);
    rst4 = 1'b1;
    #1;
    chk("c6_busy", busy4, 1'b0);
    chk("c6_done", done4, 1'b0);
    chk("c6_result", res4, 128'h0);
    chk("c6_flags", {co4, ov4}, 2'b00);
    repeat (2) @(posedge clk);
    #2 rst4 = 1'b0;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) nd++;
    end
    chk("c6_no_done", nd, 0);
    run_op(4, 128'd100, 128'd200, 1'b0, 1'b0, 0, 1'b0, r, co, ov, lat, bc);
    chk("c6_res", r, 128'd300);
    chk("c6_co", co, 1'b0);
    chk("c6_lat", lat, N4 + 1);

    // Single-word instance.
    run_op(1, 128'd1, 128'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, r, co, ov, lat, bc);
    chk("w1_res", r, 128'h0);
    chk("w1_flags", {co, ov}, 2'b10);
    chk("w1_lat", lat, 2);
    run_op(1, 128'h7FFF_FFFF, 128'd1, 1'b0, 1'b0, 0, 1'b0, r, co, ov, lat, bc);
    chk("w1_ovf_res", r, 128'h8000_0000);
    chk("w1_ovf_flags", {co, ov}, 2'b01);
    run_op(1, 128'd10, 128'd20, 1'b1, 1'b0, 0, 1'b0, r, co, ov, lat, bc);
    chk("w1_sub_res", r, 128'hFFFF_FFF6);
    chk("w1_sub_co", co, 1'b0);

    // Randomized operations; the per-cycle model checks every output.
    for (int i = 0; i < 40; i++) begin
      ra = rnd_operand();
      rb = rnd_operand();
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      e  = ref_op(ra, rb, rs, rc);
      run_op(4, ra, rb, rs, rc, int'($urandom_range(0, 4)), bit'($urandom_range(0, 1)),
             r, co, ov, lat, bc);
      chk("rnd_lat", lat, N4 + 1);
      chk("rnd_res", r, e[127:0]);
      chk("rnd_flags", {ov, co}, e[129:128]);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
